// File: rtl/calc_pkg.sv
// Shared constants and arithmetic helpers for the calculator operand-entry datapath.
package calc_pkg;

    localparam int BCD_W    = 4;
    localparam int NUM_KEYS = 10;

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } conv_state_t;

    // One Horner step of BCD-to-binary conversion; callers truncate to their width.
    function automatic logic [31:0] conv_step(input logic [31:0] acc, input logic [BCD_W-1:0] digit);
        return acc * 32'd10 + {28'd0, digit};
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_onehot_dec.sv
// Combinational one-hot digit key decoder with valid and multi-hot detection.
module key_onehot_dec
    import calc_pkg::*;
(
    input  logic [NUM_KEYS-1:0] key,
    output logic [BCD_W-1:0]    digit,
    output logic                valid,
    output logic                multi_hot
);

    function automatic logic [NUM_KEYS-1:0] bit_mask(input int b);
        logic [NUM_KEYS-1:0] m;
        for (int i = 0; i < NUM_KEYS; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

    // Each digit bit is the OR of the keys whose index has that bit set.
    generate
        for (genvar gi = 0; gi < BCD_W; gi++) begin : g_digit_bit
            localparam logic [NUM_KEYS-1:0] MASK = bit_mask(gi);
            assign digit[gi] = |(key & MASK);
        end
    endgenerate

    assign valid     = |key;
    assign multi_hot = |(key & (key - NUM_KEYS'(1)));

endmodule

// File: rtl/digit_entry_reg.sv
// Keypad operand entry: edge-detected digit/clear/backspace editing of a right-aligned
// BCD register, followed by a digit-serial BCD-to-binary converter.
module digit_entry_reg
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_KEYS-1:0]     key,
    input  logic                    clr,
    input  logic                    bksp,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic [WIDTH-1:0]        value,
    output logic                    ready,
    output logic                    done,
    output logic                    ovf,
    output logic                    err
);

    localparam int BW = BCD_W * DIGITS;

    generate
        if ((64'd1 << WIDTH) <= pow10(DIGITS) - 1) begin : g_width_check
            $error("digit_entry_reg: WIDTH too small to hold 10**DIGITS-1");
        end
    endgenerate

    logic [NUM_KEYS-1:0] key_q;
    logic                clr_q, bksp_q;
    logic [BW-1:0]       bcd_reg, bcd_next;
    logic [CW-1:0]       count_reg, count_next;
    logic [CW-1:0]       idx_reg, idx_next;
    logic [WIDTH-1:0]    acc_reg, acc_next, value_reg, value_next, step;
    conv_state_t         state_reg, state_next;
    logic                done_reg, done_next, ovf_reg, ovf_next, err_reg, err_next;

    logic [BCD_W-1:0] dig;
    logic             dig_valid, dig_multi;
    logic             dig_ev, clr_ev, bksp_ev, is_full;
    logic             start, clear;

    key_onehot_dec u_dec (
        .key       (key),
        .digit     (dig),
        .valid     (dig_valid),
        .multi_hot (dig_multi)
    );

    // A new digit needs every key released first, so key slides give no event.
    assign dig_ev  = dig_valid && (key_q == '0);
    assign clr_ev  = clr && !clr_q;
    assign bksp_ev = bksp && !bksp_q;
    assign is_full = (count_reg == CW'(DIGITS));

    always_comb begin
        bcd_next   = bcd_reg;
        count_next = count_reg;
        ovf_next   = 1'b0;
        err_next   = 1'b0;
        start      = 1'b0;
        clear      = 1'b0;
        if (clr_ev) begin
            clear = 1'b1;
        end else if (bksp_ev) begin
            if (count_reg != '0) begin
                bcd_next   = bcd_reg >> BCD_W;
                count_next = count_reg - CW'(1);
                start      = 1'b1;
            end
        end else if (dig_ev) begin
            if (dig_multi) begin
                err_next = 1'b1;
            end else if (is_full) begin
                ovf_next = 1'b1;
            end else if (!(count_reg == '0 && dig == '0)) begin
                bcd_next   = (bcd_reg << BCD_W) | BW'(dig);
                count_next = count_reg + CW'(1);
                start      = 1'b1;
            end
        end
        if (clear) begin
            bcd_next   = '0;
            count_next = '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        idx_next   = idx_reg;
        value_next = value_reg;
        done_next  = 1'b0;
        step       = WIDTH'(conv_step(32'(acc_reg), bcd_reg[idx_reg*BCD_W +: BCD_W]));
        case (state_reg)
            ST_IDLE: ;
            ST_CONV: begin
                acc_next = step;
                if (idx_reg == '0) begin
                    value_next = step;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    idx_next = idx_reg - CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // An edit discards the in-flight result; value only ever reflects a full pass.
        if (start) begin
            state_next = ST_CONV;
            acc_next   = '0;
            idx_next   = CW'(DIGITS - 1);
            value_next = value_reg;
            done_next  = 1'b0;
        end
        if (clear) begin
            state_next = ST_IDLE;
            acc_next   = '0;
            idx_next   = '0;
            value_next = '0;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            clr_q     <= 1'b0;
            bksp_q    <= 1'b0;
            bcd_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            key_q     <= key;
            clr_q     <= clr;
            bksp_q    <= bksp;
            bcd_reg   <= bcd_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            err_reg   <= err_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            idx_reg   <= '0;
            value_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            idx_reg   <= idx_next;
            value_reg <= value_next;
            done_reg  <= done_next;
        end
    end

    assign bcd   = bcd_reg;
    assign count = count_reg;
    assign full  = is_full;
    assign value = value_reg;
    assign ready = (state_reg == ST_IDLE);
    assign done  = done_reg;
    assign ovf   = ovf_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_digit_entry_reg.sv
// Self-checking bench for digit_entry_reg: directed scenarios plus randomized edits
// against a decimal-arithmetic model of the entered operand.
module tb_digit_entry_reg;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 14;
    localparam int CW     = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [9:0]        key = '0;
    logic              clr = 1'b0;
    logic              bksp = 1'b0;
    logic [15:0]       bcd;
    logic [CW-1:0]     count;
    logic              full;
    logic [WIDTH-1:0]  value;
    logic              ready, done, ovf, err;

    int vectors = 0;
    int miscompares = 0;
    int m_val = 0;
    int m_cnt = 0;

    digit_entry_reg #(.DIGITS(DIGITS), .WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .clr(clr), .bksp(bksp),
        .bcd(bcd), .count(count), .full(full), .value(value),
        .ready(ready), .done(done), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic m_digit(input int d);
        if (m_cnt < DIGITS && !(m_cnt == 0 && d == 0)) begin
            m_val = m_val * 10 + d;
            m_cnt++;
        end
    endtask

    task automatic m_bksp();
        if (m_cnt > 0) begin
            m_val = m_val / 10;
            m_cnt--;
        end
    endtask

    task automatic m_clear();
        m_val = 0;
        m_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int d, input int hold, input int gap);
        key = 10'd1 << d;
        m_digit(d);
        repeat (hold) tick();
        key = '0;
        repeat (gap) tick();
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        m_clear();
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL settle_timeout: ready=%b required 1 after %0d cycles", ready, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++; if (bcd !== 16'h0) begin miscompares++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (value !== '0) begin miscompares++; $display("FAIL reset_value: got %0d want 0", value); end
        vectors++; if ({full, ready, done, ovf, err} !== 5'b01000) begin miscompares++; $display("FAIL reset_flags: got full/ready/done/ovf/err=%b want 01000", {full, ready, done, ovf, err}); end
        rst_n = 1'b1;
        tick();
        m_clear();
    endtask

    task automatic test_basic();
        int early;
        press(1, 3, 2);
        key = 10'd1 << 3;
        m_digit(3);
        tick();
        vectors++; if (bcd !== 16'h0013) begin miscompares++; $display("FAIL basic_bcd: got %h want 0013", bcd); end
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL basic_count: got %0d want 2", count); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL basic_busy: ready=%b want 0", ready); end
        early = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (done) early++;
        end
        vectors++; if (early !== 0) begin miscompares++; $display("FAIL basic_early_done: got %0d pulses want 0", early); end
        tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done_latency: done=%b want 1 at 4th edge", done); end
        vectors++; if (value !== 14'd13) begin miscompares++; $display("FAIL basic_value: got %0d want 13", value); end
        key = '0;
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: done=%b want 0", done); end
        $display("basic: bcd=%h value=%0d", bcd, value);
    endtask

    task automatic test_leading_zero();
        int dones;
        clear_pulse();
        key = 10'd1;
        tick();
        vectors++; if (count !== '0 || ready !== 1'b1) begin miscompares++; $display("FAIL lz_ignored: count=%0d ready=%b want 0/1", count, ready); end
        dones = 0;
        repeat (5) begin tick(); if (done) dones++; end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL lz_no_done: got %0d pulses want 0", dones); end
        key = '0;
        tick();
        press(7, 3, 2);
        press(0, 3, 2);
        settle();
        vectors++; if (bcd !== 16'h0070) begin miscompares++; $display("FAIL lz_bcd: got %h want 0070", bcd); end
        vectors++; if (value !== 14'd70) begin miscompares++; $display("FAIL lz_value: got %0d want 70", value); end
        $display("leading_zero: bcd=%h value=%0d", bcd, value);
    endtask

    task automatic test_full_ovf();
        int pulses;
        clear_pulse();
        repeat (4) press(9, 3, 2);
        settle();
        vectors++; if (value !== 14'd9999) begin miscompares++; $display("FAIL full_value: got %0d want 9999", value); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %b want 1", full); end
        key = 10'd1 << 5;
        tick();
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse: got %b want 1", ovf); end
        vectors++; if (bcd !== 16'h9999) begin miscompares++; $display("FAIL ovf_bcd: got %h want 9999", bcd); end
        pulses = 1;
        repeat (9) begin tick(); if (ovf) pulses++; end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL ovf_hold: got %0d pulses want 1", pulses); end
        key = '0;
        tick();
        $display("full_ovf: bcd=%h pulses=%0d", bcd, pulses);
    endtask

    task automatic test_bksp_clr();
        clear_pulse();
        for (int d = 1; d <= 4; d++) press(d, 3, 2);
        settle();
        bksp = 1'b1;
        m_bksp();
        tick();
        bksp = 1'b0;
        vectors++; if (bcd !== 16'h0123 || count !== 3'd3) begin miscompares++; $display("FAIL bksp_bcd: got %h/%0d want 0123/3", bcd, count); end
        settle();
        vectors++; if (value !== 14'd123) begin miscompares++; $display("FAIL bksp_value: got %0d want 123", value); end
        clr = 1'b1;
        key = 10'd1 << 5;
        tick();
        m_clear();
        vectors++; if (bcd !== 16'h0 || count !== '0) begin miscompares++; $display("FAIL clr_prio: got %h/%0d want 0000/0", bcd, count); end
        vectors++; if (value !== '0 || ready !== 1'b1) begin miscompares++; $display("FAIL clr_value: value=%0d ready=%b want 0/1", value, ready); end
        clr = 1'b0;
        key = '0;
        tick();
        $display("bksp_clr: bcd=%h value=%0d", bcd, value);
    endtask

    task automatic test_err_restart();
        int dones, first;
        key = 10'h006;
        tick();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_pulse: got %b want 1", err); end
        vectors++; if (bcd !== 16'h0 || count !== '0) begin miscompares++; $display("FAIL err_nochange: got %h/%0d want 0000/0", bcd, count); end
        key = '0;
        tick();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_single: got %b want 0", err); end
        press(1, 3, 2);
        press(2, 3, 2);
        settle();
        key = 10'd1 << 8;
        m_digit(8);
        tick();
        key = '0;
        tick();
        key = 10'd1 << 4;
        m_digit(4);
        tick();
        key = '0;
        dones = 0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (done) begin
                dones++;
                if (first == 0) first = i;
            end
        end
        vectors++; if (dones !== 1 || first !== 4) begin miscompares++; $display("FAIL restart_done: got %0d pulses first at %0d want 1 at 4", dones, first); end
        vectors++; if (value !== 14'd1284 || bcd !== 16'h1284) begin miscompares++; $display("FAIL restart_value: got %0d/%h want 1284/1284", value, bcd); end
        $display("err_restart: bcd=%h value=%0d", bcd, value);
    endtask

    task automatic test_async_reset();
        key = 10'd1 << 5;
        tick();
        key = '0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bcd !== 16'h0 || count !== '0 || value !== '0) begin miscompares++; $display("FAIL async_rst_data: got %h/%0d/%0d want 0", bcd, count, value); end
        vectors++; if ({full, ready, done, ovf, err} !== 5'b01000) begin miscompares++; $display("FAIL async_rst_flags: got %b want 01000", {full, ready, done, ovf, err}); end
        tick();
        tick();
        rst_n = 1'b1;
        m_clear();
        tick();
        press(6, 3, 2);
        settle();
        vectors++; if (value !== 14'd6 || bcd !== 16'h0006) begin miscompares++; $display("FAIL post_rst_press: got %0d/%h want 6/0006", value, bcd); end
        $display("async_reset: bcd=%h value=%0d", bcd, value);
    endtask

    task automatic test_random();
        int op, d, b1, b2;
        logic exp_ovf;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 99);
            if (op < 6) begin
                clr = 1'b1;
                tick();
                clr = 1'b0;
                m_clear();
                $display("rand %0d: clear", n);
            end else if (op < 20) begin
                bksp = 1'b1;
                tick();
                bksp = 1'b0;
                m_bksp();
                $display("rand %0d: backspace", n);
            end else if (op < 30) begin
                b1 = $urandom_range(0, 9);
                b2 = (b1 + 1 + $urandom_range(0, 8)) % 10;
                key = (10'd1 << b1) | (10'd1 << b2);
                tick();
                vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL rand_err: key=%h err=%b want 1", key, err); end
                key = '0;
                $display("rand %0d: multi-hot key bits %0d,%0d", n, b1, b2);
            end else begin
                d = $urandom_range(0, 9);
                exp_ovf = (m_cnt == DIGITS);
                key = 10'd1 << d;
                tick();
                vectors++; if (ovf !== exp_ovf) begin miscompares++; $display("FAIL rand_ovf: digit %0d ovf=%b want %b", d, ovf, exp_ovf); end
                key = '0;
                m_digit(d);
                $display("rand %0d: digit %0d", n, d);
            end
            tick();
            settle();
            vectors++; if (bcd !== to_bcd(m_val) || count !== CW'(m_cnt)) begin miscompares++; $display("FAIL rand_bcd: got %h/%0d want %h/%0d", bcd, count, to_bcd(m_val), m_cnt); end
            vectors++; if (value !== WIDTH'(m_val)) begin miscompares++; $display("FAIL rand_value: got %0d want %0d", value, m_val); end
            vectors++; if (full !== (m_cnt == DIGITS)) begin miscompares++; $display("FAIL rand_full: got %b want %b", full, m_cnt == DIGITS); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_leading_zero();
        test_full_ovf();
        test_bksp_clr();
        test_err_restart();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/digit_entry_reg.md
# digit_entry_reg

Parametrised multi-digit operand entry register for the calculator datapath. It is the sequential successor of the one-hot digit decoder. It takes the ten one-hot digit keys plus clear and backspace, detects key-press events, and maintains a right-aligned BCD operand of up to DIGITS digits. A multi-cycle BCD-to-binary converter then produces the binary operand for the ALU. It sits between the keypad front end (already synchronised and debounced) and the operand registers.

## Interface
- DIGITS, 4: maximum number of entered digits.
- WIDTH, 14: binary output width. Must satisfy 2^WIDTH > 10^DIGITS - 1 (elaboration error otherwise).
- CW, $clog2(DIGITS+1): width of the digit counter.

- clk  in  1  clock. All state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key  in  10  one-hot digit keys, bit i = digit i. Level, held while pressed.
- clr  in  1  clear key, level.
- bksp  in  1  backspace key, level.
- bcd  out  4*DIGITS  entered digits, least significant digit in [3:0].
- count  out  CW  number of significant digits entered.
- full  out  1  count == DIGITS.
- value  out  WIDTH  binary equivalent of bcd, valid when ready=1.
- ready  out  1  converter idle; value consistent with bcd.
- done  out  1  one-cycle pulse when a conversion completes.
- ovf  out  1  one-cycle pulse: digit press rejected because full.
- err  out  1  one-cycle pulse: press event with more than one key bit set.

## Operation
- Registered samples: key_q, clr_q, bksp_q.
- Digit event: key != 0 && key_q == 0. A new digit is accepted only after all keys have been released. Holding a key, or sliding from one key to another, gives no further events.
- Clear and backspace events are rising edges of clr and bksp.
- Priority in the same cycle: clr > bksp > digit. Lower-priority events in that cycle are discarded.
- Multi-hot digit event: err pulses; no other state change.
- Digit d accepted:
  - count == DIGITS: ovf pulses; no change.
  - count == 0 and d == 0: leading zero, ignored silently with no conversion.
  - otherwise: bcd <= {bcd[4*DIGITS-5:0], d}, count++, conversion starts.
- Backspace:
  - count == 0: no-op.
  - otherwise: bcd >>= 4 (zero fill), count--, conversion starts.
- Clear: bcd, count and value go to 0; state goes to IDLE, which aborts any conversion; no done pulse.
- Converter FSM:
  - IDLE: ready=1.
  - CONV: idx runs from DIGITS-1 down to 0; acc <= acc*10 + bcd digit[idx], computed modulo 2^WIDTH, which cannot overflow given the WIDTH rule.
  - On idx == 0, value <= result, done is asserted, and the FSM returns to IDLE.
  - Any accepted edit during CONV restarts the conversion with acc=0, idx=DIGITS-1, using the new bcd. value keeps its old result until a conversion finishes.
- Reset values: bcd=0, count=0, value=0, full=0, ready=1, done=0, ovf=0, err=0, FSM=IDLE. Samples reset to 0.

## Timing
- Event detected during the cycle before edge N. At edge N, bcd and count update and the FSM enters CONV (ready=0).
- Conversion runs for DIGITS edges. At edge N+DIGITS, value is written, ready=1 and done=1 for one cycle. Latency from the edit edge to a valid value is DIGITS cycles.
- ovf and err are registered and high for the cycle after edge N.
- Clear takes effect at edge N: outputs are zero and ready=1 immediately.
- Reset is asynchronous: outputs reach their reset values without a clock, including in the middle of a conversion.

## Structure
- calc_pkg holds BCD_W=4, NUM_KEYS=10, and a function for the conversion step (acc*10 + digit).
- One sub-module, key_onehot_dec: combinational 10-bit one-hot to 4-bit digit, with a valid output and a multi_hot flag. It is instantiated once on key.
- Conversion FSM and entry register share one always block per register group; no further hierarchy.

## Test plan
- Reset, then press 1, then 3 (each held 3 cycles, released 2 cycles) -> bcd=16'h0013, count=2, value=13 with done exactly 4 cycles after the press-3 edge.
- Press 0 with count=0 -> count stays 0, no done pulse. Then press 7, 0 -> bcd=16'h0070, value=70.
- Enter 9,9,9,9 -> value=9999, full=1. Press 5 -> ovf pulse, bcd unchanged. Hold 5 for 10 cycles -> only one ovf pulse.
- From 1234, assert bksp -> bcd=16'h0123, value=123. Assert clr and key 5 in the same cycle -> bcd=0, count=0, value=0, ready=1 at that edge.
- key=10'h006 -> err pulse, no change. Press 4 during CONV, 2 cycles after entering 8 from 12 -> conversion restarts, and one done gives value=1284.
- Drop rst_n during CONV -> all outputs return to reset values asynchronously. After release, the first press of 6 -> value=6.
